// File: rtl/billiard_pkg.sv
// Shared constants, the per-frame collision report type and a hole-index helper.
package billiard_pkg;

    localparam int unsigned NUM_HOLES  = 6;
    localparam int unsigned HOLE_IDX_W = 3;

    // One frame's collision results as seen by the game logic.
    typedef struct packed {
        logic                  hitWR;
        logic                  hitWB;
        logic                  hitRB;
        logic                  whiteInHole;
        logic                  redInHole;
        logic [HOLE_IDX_W-1:0] whiteHoleIdx;
        logic [HOLE_IDX_W-1:0] redHoleIdx;
    } hit_report_t;

    // Index of the lowest set hole bit; 0 when no bit is set.
    function automatic logic [HOLE_IDX_W-1:0] lowest_hole(input logic [NUM_HOLES-1:0] holes);
        logic [HOLE_IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(NUM_HOLES) - 1; i >= 0; i--) begin
            if (holes[i]) begin
                idx = HOLE_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/overlap_counter.sv
// Saturating per-frame overlap counter with a threshold compare on the registered count.
module overlap_counter #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned MIN_OVERLAP = 4
) (
    input  logic clk,
    input  logic resetN,
    input  logic clr,
    input  logic inc,
    output logic reached
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] MinVal = CNT_W'(MIN_OVERLAP);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Frame restart counts the current pixel as pixel 0; otherwise count up until saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? CNT_W'(1) : '0;
        end else if (inc && (count_q != CntMax)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Compare uses the count accumulated up to the previous cycle.
    assign reached = (count_q >= MinVal);

endmodule

// File: rtl/hit_detector.sv
// Counts overlapping draw requests per frame and reports object-pair collisions once per frame.
module hit_detector
    import billiard_pkg::*;
#(
    parameter int unsigned MIN_OVERLAP = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic [NUM_HOLES-1:0]  holeDR,
    input  logic                  whiteBallDR,
    input  logic                  redBallDR,
    input  logic                  bordersDR,
    output logic                  frameDone,
    output logic                  hitWR,
    output logic                  hitWB,
    output logic                  hitRB,
    output logic                  whiteInHole,
    output logic                  redInHole,
    output logic [HOLE_IDX_W-1:0] whiteHoleIdx,
    output logic [HOLE_IDX_W-1:0] redHoleIdx
);

    localparam int unsigned NumPairs = 5;
    // Pair slots: 0 W&R, 1 W&B, 2 R&B, 3 W&hole, 4 R&hole.

    logic                  any_hole;
    logic                  white_hole_ovl;
    logic                  red_hole_ovl;
    logic [NumPairs-1:0]   pair_ovl;
    logic [NumPairs-1:0]   reached;
    logic [HOLE_IDX_W-1:0] cur_hole_idx;

    logic                  armed_q;
    logic                  white_cap_q, white_cap_d;
    logic                  red_cap_q, red_cap_d;
    logic [HOLE_IDX_W-1:0] white_idx_q, white_idx_d;
    logic [HOLE_IDX_W-1:0] red_idx_q, red_idx_d;
    logic                  frame_done_q, frame_done_d;
    hit_report_t           report_q, report_d;

    assign any_hole       = |holeDR;
    assign white_hole_ovl = whiteBallDR & any_hole;
    assign red_hole_ovl   = redBallDR & any_hole;
    assign cur_hole_idx   = lowest_hole(holeDR);
    assign pair_ovl       = {red_hole_ovl, white_hole_ovl, redBallDR & bordersDR,
                             whiteBallDR & bordersDR, whiteBallDR & redBallDR};

    for (genvar g = 0; g < NumPairs; g++) begin : g_pair
        overlap_counter #(
            .CNT_W       (CNT_W),
            .MIN_OVERLAP (MIN_OVERLAP)
        ) u_cnt (
            .clk     (clk),
            .resetN  (resetN),
            .clr     (startOfFrame),
            .inc     (pair_ovl[g]),
            .reached (reached[g])
        );
    end

    // Latch the first hole touched by each ball this frame; frame start re-opens the capture.
    always_comb begin
        white_cap_d = startOfFrame ? 1'b0 : white_cap_q;
        white_idx_d = white_idx_q;
        red_cap_d   = startOfFrame ? 1'b0 : red_cap_q;
        red_idx_d   = red_idx_q;
        if (!white_cap_d && white_hole_ovl) begin
            white_cap_d = 1'b1;
            white_idx_d = cur_hole_idx;
        end
        if (!red_cap_d && red_hole_ovl) begin
            red_cap_d = 1'b1;
            red_idx_d = cur_hole_idx;
        end
    end

    // Event flags pulse for one cycle; hole indices hold until the next report.
    always_comb begin
        report_d             = report_q;
        report_d.hitWR       = 1'b0;
        report_d.hitWB       = 1'b0;
        report_d.hitRB       = 1'b0;
        report_d.whiteInHole = 1'b0;
        report_d.redInHole   = 1'b0;
        frame_done_d         = 1'b0;
        // The partial frame before the first frame start is discarded.
        if (startOfFrame && armed_q) begin
            frame_done_d          = 1'b1;
            report_d.hitWR        = reached[0];
            report_d.hitWB        = reached[1];
            report_d.hitRB        = reached[2];
            report_d.whiteInHole  = reached[3];
            report_d.redInHole    = reached[4];
            report_d.whiteHoleIdx = reached[3] ? white_idx_q : '0;
            report_d.redHoleIdx   = reached[4] ? red_idx_q : '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            armed_q      <= 1'b0;
            white_cap_q  <= 1'b0;
            white_idx_q  <= '0;
            red_cap_q    <= 1'b0;
            red_idx_q    <= '0;
            frame_done_q <= 1'b0;
            report_q     <= '0;
        end else begin
            armed_q      <= armed_q | startOfFrame;
            white_cap_q  <= white_cap_d;
            white_idx_q  <= white_idx_d;
            red_cap_q    <= red_cap_d;
            red_idx_q    <= red_idx_d;
            frame_done_q <= frame_done_d;
            report_q     <= report_d;
        end
    end

    assign frameDone    = frame_done_q;
    assign hitWR        = report_q.hitWR;
    assign hitWB        = report_q.hitWB;
    assign hitRB        = report_q.hitRB;
    assign whiteInHole  = report_q.whiteInHole;
    assign redInHole    = report_q.redInHole;
    assign whiteHoleIdx = report_q.whiteHoleIdx;
    assign redHoleIdx   = report_q.redHoleIdx;

endmodule

// File: tb/tb_hit_detector.sv
// Randomized and directed bench for hit_detector against a frame-level reference model.
module tb_hit_detector;

    localparam int unsigned MinOv = 4;
    localparam int unsigned CntW  = 3;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic [5:0] holeDR;
    logic       whiteBallDR;
    logic       redBallDR;
    logic       bordersDR;
    logic       frameDone;
    logic       hitWR, hitWB, hitRB, whiteInHole, redInHole;
    logic [2:0] whiteHoleIdx, redHoleIdx;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain pixel tallies per frame, first-touched hole per ball.
    int c_wr, c_wb, c_rb, c_wh, c_rh;
    int m_widx, m_ridx;
    bit m_wcap, m_rcap;
    bit m_armed;
    int e_fd, e_flags, e_widx, e_ridx;

    hit_detector #(
        .MIN_OVERLAP (MinOv),
        .CNT_W       (CntW)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .holeDR       (holeDR),
        .whiteBallDR  (whiteBallDR),
        .redBallDR    (redBallDR),
        .bordersDR    (bordersDR),
        .frameDone    (frameDone),
        .hitWR        (hitWR),
        .hitWB        (hitWB),
        .hitRB        (hitRB),
        .whiteInHole  (whiteInHole),
        .redInHole    (redInHole),
        .whiteHoleIdx (whiteHoleIdx),
        .redHoleIdx   (redHoleIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int first_hole(input logic [5:0] h);
        for (int i = 0; i < 6; i++) begin
            if (h[i]) return i;
        end
        return 0;
    endfunction

    function automatic int obs_flags();
        return int'({hitWR, hitWB, hitRB, whiteInHole, redInHole});
    endfunction

    task automatic model_clear();
        c_wr = 0; c_wb = 0; c_rb = 0; c_wh = 0; c_rh = 0;
        m_widx = 0; m_ridx = 0; m_wcap = 0; m_rcap = 0; m_armed = 0;
        e_fd = 0; e_flags = 0; e_widx = 0; e_ridx = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_frameDone"}, int'(frameDone), e_fd);
        check({tag, "_flags"}, obs_flags(), e_flags);
        check({tag, "_whiteIdx"}, int'(whiteHoleIdx), e_widx);
        check({tag, "_redIdx"}, int'(redHoleIdx), e_ridx);
    endtask

    // One pixel: drive, predict the registered outputs, clock, compare.
    task automatic step(input bit sof, input logic [5:0] hole, input bit w, input bit r,
                        input bit b);
        bit anyh;
        startOfFrame = sof;
        holeDR       = hole;
        whiteBallDR  = w;
        redBallDR    = r;
        bordersDR    = b;
        anyh         = (hole != 6'd0);
        e_fd    = 0;
        e_flags = 0;
        if (sof && m_armed) begin
            e_fd    = 1;
            e_flags = ((c_wr >= MinOv) ? 16 : 0) + ((c_wb >= MinOv) ? 8 : 0) +
                      ((c_rb >= MinOv) ? 4 : 0) + ((c_wh >= MinOv) ? 2 : 0) +
                      ((c_rh >= MinOv) ? 1 : 0);
            e_widx  = (c_wh >= MinOv) ? m_widx : 0;
            e_ridx  = (c_rh >= MinOv) ? m_ridx : 0;
        end
        if (sof) begin
            c_wr = 0; c_wb = 0; c_rb = 0; c_wh = 0; c_rh = 0;
            m_wcap = 0; m_rcap = 0; m_armed = 1;
        end
        if (w && r) c_wr++;
        if (w && b) c_wb++;
        if (r && b) c_rb++;
        if (w && anyh) c_wh++;
        if (r && anyh) c_rh++;
        if (w && anyh && !m_wcap) begin m_wcap = 1; m_widx = first_hole(hole); end
        if (r && anyh && !m_rcap) begin m_rcap = 1; m_ridx = first_hole(hole); end
        @(posedge clk);
        #1;
        compare_all("px");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #2;
        resetN = 1'b0;
        #1;
        model_clear();
        compare_all("rst");
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        holeDR       = '0;
        whiteBallDR  = 1'b0;
        redBallDR    = 1'b0;
        bordersDR    = 1'b0;
        model_clear();
        #12;
        compare_all("reset");
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        // Partial frame then first frame start: no report yet.
        for (int i = 0; i < 5; i++) step(1'b0, 6'd0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
        check("first_sof_no_done", int'(frameDone), 0);

        // 10 px of W&R.
        for (int i = 0; i < 10; i++) step(1'b0, 6'd0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
        check("t1_done", int'(frameDone), 1);
        check("t1_flags", obs_flags(), 16);
        idle(1);
        check("t1_done_pulse", int'(frameDone), 0);

        // Threshold boundary: 3 then 4 px of W&B.
        for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
        check("t2_hitWB_3px", int'(hitWB), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 6'd0, 1'b1, 1'b0, 1'b1);
        check("t2_hitWB_4px_pending", int'(hitWB), 0);
        step(1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
        check("t2_back_to_back_done", int'(frameDone), 1);

        // Hole capture keeps the first hole even when a later one is touched.
        for (int i = 0; i < 5; i++) step(1'b0, 6'b001100, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 6'b000001, 1'b1, 1'b0, 1'b0);
        // Frame start carrying a W&R pixel that belongs to the next frame.
        step(1'b1, 6'd0, 1'b1, 1'b1, 1'b0);
        check("t3_whiteInHole", int'(whiteInHole), 1);
        check("t3_whiteIdx", int'(whiteHoleIdx), 2);
        check("t4_old_hitWR", int'(hitWR), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
        check("t4_hitWR_shared_px", int'(hitWR), 1);
        check("idx_held_to_zero", int'(whiteHoleIdx), 0);

        // Saturation and mid-frame reset.
        for (int i = 0; i < 20; i++) step(1'b0, 6'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
        check("t5_hitRB_sat", int'(hitRB), 1);
        for (int i = 0; i < 6; i++) step(1'b0, 6'd0, 1'b0, 1'b1, 1'b1);
        do_reset();
        idle(2);
        step(1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
        check("t5_no_done_after_rst", int'(frameDone), 0);

        // Everything overlapping at once.
        for (int i = 0; i < 6; i++) step(1'b0, 6'b000001, 1'b1, 1'b1, 1'b1);
        step(1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
        check("t6_flags", obs_flags(), 31);
        check("t6_whiteIdx", int'(whiteHoleIdx), 0);
        check("t6_redIdx", int'(redHoleIdx), 0);

        // Random frames, including single-pixel frames and long saturating runs.
        for (int f = 0; f < 60; f++) begin
            int len;
            len = (f % 7 == 3) ? 1 : int'($urandom_range(1, 24));
            for (int p = 0; p < len; p++) begin
                logic [5:0] h;
                h = ($urandom_range(0, 9) < 4) ? 6'($urandom_range(1, 63)) : 6'd0;
                step(p == 0, h, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
                     $urandom_range(0, 9) < 4);
            end
            if (f == 40) do_reset();
        end
        step(1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
